// File: rtl/cmlk_3d_pkg.sv
// Shared helpers for the 3D sensor stream width upsizer: default sizes,
// derived widths and the beat-index to output-lane mapping.
package cmlk_3d_pkg;

    localparam int unsigned DEF_DIN_W = 16;
    localparam int unsigned DEF_RATIO = 2;
    localparam int unsigned DEF_CNT_W = 32;

    function automatic int unsigned dout_w(input int unsigned din_w, input int unsigned ratio);
        return din_w * ratio;
    endfunction

    function automatic int unsigned idx_w(input int unsigned ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    // Lane that receives beat number idx of a word.
    function automatic int unsigned lane_sel(input int unsigned idx, input int unsigned ratio,
                                             input bit msb_first);
        return msb_first ? (ratio - 1 - idx) : idx;
    endfunction

endpackage

// File: rtl/cmlk_3d_upsizer_outreg.sv
// Output word holding register: loads completed words, drops valid on transfer,
// and counts transferred words.
module cmlk_3d_upsizer_outreg
    import cmlk_3d_pkg::*;
#(
    parameter int unsigned DOUT_W = 32,
    parameter int unsigned KEEP_W = 2,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DOUT_W-1:0] load_data,
    input  logic [KEEP_W-1:0] load_keep,
    input  logic              load_last,
    input  logic              m_ready,
    output logic [DOUT_W-1:0] m_data,
    output logic [KEEP_W-1:0] m_keep,
    output logic              m_last,
    output logic              m_valid,
    output logic [CNT_W-1:0]  word_cnt
);

    logic xfer;

    assign xfer = m_valid && m_ready;

    // A load only happens when the slot is free or draining, so it never
    // overwrites a word the downstream has not yet taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_data   <= '0;
            m_keep   <= '0;
            m_last   <= 1'b0;
            m_valid  <= 1'b0;
            word_cnt <= '0;
        end else begin
            if (load) begin
                m_data  <= load_data;
                m_keep  <= load_keep;
                m_last  <= load_last;
                m_valid <= 1'b1;
            end else if (xfer) begin
                m_valid <= 1'b0;
            end
            if (xfer) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/cmlk_3d_width_upsizer.sv
// Packs RATIO consecutive DIN_W-bit beats into one output word, with early
// flush on s_last, per-lane keep mask and full valid/ready backpressure.
module cmlk_3d_width_upsizer
    import cmlk_3d_pkg::*;
#(
    parameter int unsigned DIN_W     = DEF_DIN_W,
    parameter int unsigned RATIO     = DEF_RATIO,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DIN_W-1:0]       s_data,
    input  logic                   s_valid,
    input  logic                   s_last,
    output logic                   s_ready,
    output logic [DIN_W*RATIO-1:0] m_data,
    output logic [RATIO-1:0]       m_keep,
    output logic                   m_last,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [CNT_W-1:0]       word_cnt
);

    localparam int unsigned DOUT_W = dout_w(DIN_W, RATIO);
    localparam int unsigned IDX_W  = idx_w(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    logic [DOUT_W-1:0] acc_data;
    logic [RATIO-1:0]  acc_keep;
    logic [IDX_W-1:0]  idx;
    logic [DOUT_W-1:0] merged_data;
    logic [RATIO-1:0]  merged_keep;
    logic              acc;
    logic              complete;

    // Ready depends only on the output slot, never on the incoming beat.
    assign s_ready  = !m_valid || m_ready;
    assign acc      = s_valid && s_ready;
    assign complete = acc && ((idx == LAST_IDX) || s_last);

    // Partial word with the current beat merged into its lane.
    always_comb begin
        merged_data = acc_data;
        merged_keep = acc_keep;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (lane_sel(32'(idx), RATIO, MSB_FIRST) == i) begin
                merged_data[i*DIN_W +: DIN_W] = s_data;
                merged_keep[i]                = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_data <= '0;
            acc_keep <= '0;
            idx      <= '0;
        end else if (complete) begin
            acc_data <= '0;
            acc_keep <= '0;
            idx      <= '0;
        end else if (acc) begin
            acc_data <= merged_data;
            acc_keep <= merged_keep;
            idx      <= idx + IDX_W'(1);
        end
    end

    cmlk_3d_upsizer_outreg #(
        .DOUT_W (DOUT_W),
        .KEEP_W (RATIO),
        .CNT_W  (CNT_W)
    ) u_outreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (complete),
        .load_data (merged_data),
        .load_keep (merged_keep),
        .load_last (s_last),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_keep    (m_keep),
        .m_last    (m_last),
        .m_valid   (m_valid),
        .word_cnt  (word_cnt)
    );

endmodule

// File: tb/tb_cmlk_3d_width_upsizer.sv
// Bench for cmlk_3d_width_upsizer: three configurations, directed scenarios
// plus a randomized handshake run against a word-packing reference model.
module tb_cmlk_3d_width_upsizer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // a: defaults (16-bit, ratio 2, MSB first, 32-bit counter)
    logic [15:0] a_s_data;
    logic        a_s_valid, a_s_last, a_s_ready, a_m_last, a_m_valid, a_m_ready;
    logic [31:0] a_m_data;
    logic [1:0]  a_m_keep;
    logic [31:0] a_word_cnt;
    // b: 8-bit, ratio 4, LSB first, 4-bit counter
    logic [7:0]  b_s_data;
    logic        b_s_valid, b_s_last, b_s_ready, b_m_last, b_m_valid, b_m_ready;
    logic [31:0] b_m_data;
    logic [3:0]  b_m_keep;
    logic [3:0]  b_word_cnt;
    // c: 8-bit, ratio 4, MSB first, 32-bit counter
    logic [7:0]  c_s_data;
    logic        c_s_valid, c_s_last, c_s_ready, c_m_last, c_m_valid, c_m_ready;
    logic [31:0] c_m_data;
    logic [3:0]  c_m_keep;
    logic [31:0] c_word_cnt;

    cmlk_3d_width_upsizer u_a (
        .clk(clk), .rst_n(rst_n), .s_data(a_s_data), .s_valid(a_s_valid), .s_last(a_s_last),
        .s_ready(a_s_ready), .m_data(a_m_data), .m_keep(a_m_keep), .m_last(a_m_last),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .word_cnt(a_word_cnt)
    );

    cmlk_3d_width_upsizer #(.DIN_W(8), .RATIO(4), .MSB_FIRST(1'b0), .CNT_W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .s_data(b_s_data), .s_valid(b_s_valid), .s_last(b_s_last),
        .s_ready(b_s_ready), .m_data(b_m_data), .m_keep(b_m_keep), .m_last(b_m_last),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .word_cnt(b_word_cnt)
    );

    cmlk_3d_width_upsizer #(.DIN_W(8), .RATIO(4), .MSB_FIRST(1'b1), .CNT_W(32)) u_c (
        .clk(clk), .rst_n(rst_n), .s_data(c_s_data), .s_valid(c_s_valid), .s_last(c_s_last),
        .s_ready(c_s_ready), .m_data(c_m_data), .m_keep(c_m_keep), .m_last(c_m_last),
        .m_valid(c_m_valid), .m_ready(c_m_ready), .word_cnt(c_word_cnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic a_beat(input logic [15:0] d, input logic l);
        a_s_valid = 1'b1; a_s_data = d; a_s_last = l;
        tick();
        a_s_valid = 1'b0; a_s_last = 1'b0;
    endtask

    task automatic b_beat(input logic [7:0] d, input logic l);
        b_s_valid = 1'b1; b_s_data = d; b_s_last = l;
        tick();
        b_s_valid = 1'b0; b_s_last = 1'b0;
    endtask

    task automatic c_beat(input logic [7:0] d, input logic l);
        c_s_valid = 1'b1; c_s_data = d; c_s_last = l;
        tick();
        c_s_valid = 1'b0; c_s_last = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({a_m_valid, a_m_data, a_m_keep, a_m_last, a_word_cnt, a_s_ready} !==
            {1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_a: got v=%b d=%h k=%b l=%b cnt=%h rdy=%b, expected all 0 and rdy=1",
                     a_m_valid, a_m_data, a_m_keep, a_m_last, a_word_cnt, a_s_ready);
        end
        n_checks++;
        if ({b_m_valid, b_m_data, b_m_keep, b_m_last, b_word_cnt, b_s_ready} !==
            {1'b0, 32'h0, 4'h0, 1'b0, 4'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_b: got v=%b d=%h k=%b l=%b cnt=%h rdy=%b, expected all 0 and rdy=1",
                     b_m_valid, b_m_data, b_m_keep, b_m_last, b_word_cnt, b_s_ready);
        end
        n_checks++;
        if ({c_m_valid, c_m_data, c_m_keep, c_m_last, c_word_cnt, c_s_ready} !==
            {1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_c: got v=%b d=%h k=%b l=%b cnt=%h rdy=%b, expected all 0 and rdy=1",
                     c_m_valid, c_m_data, c_m_keep, c_m_last, c_word_cnt, c_s_ready);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        a_m_ready = 1'b1;
        a_beat(16'h1111, 1'b0);
        n_checks++;
        if (a_m_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_early_valid: got %b expected 0", a_m_valid);
        end
        a_beat(16'h2222, 1'b0);
        n_checks++;
        if ({a_m_valid, a_m_data, a_m_keep, a_m_last} !== {1'b1, 32'h11112222, 2'b11, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_word0: got v=%b d=%h k=%b l=%b expected 1 11112222 11 0",
                     a_m_valid, a_m_data, a_m_keep, a_m_last);
        end
        a_beat(16'h3333, 1'b0);
        n_checks++;
        if ({a_m_valid, a_word_cnt} !== {1'b0, 32'd1}) begin
            n_fail++; $display("FAIL basic_mid: got v=%b cnt=%0d expected 0 1", a_m_valid, a_word_cnt);
        end
        a_beat(16'h4444, 1'b0);
        n_checks++;
        if ({a_m_valid, a_m_data, a_m_keep, a_m_last} !== {1'b1, 32'h33334444, 2'b11, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_word1: got v=%b d=%h k=%b l=%b expected 1 33334444 11 0",
                     a_m_valid, a_m_data, a_m_keep, a_m_last);
        end
        tick();
        n_checks++;
        if ({a_m_valid, a_word_cnt} !== {1'b0, 32'd2}) begin
            n_fail++; $display("FAIL basic_cnt: got v=%b cnt=%0d expected 0 2", a_m_valid, a_word_cnt);
        end
    endtask

    task automatic test_lsb_first;
        b_m_ready = 1'b1;
        b_beat(8'hA1, 1'b0);
        b_beat(8'hB2, 1'b0);
        b_beat(8'hC3, 1'b0);
        n_checks++;
        if (b_m_valid !== 1'b0) begin
            n_fail++; $display("FAIL lsb_early_valid: got %b expected 0", b_m_valid);
        end
        b_beat(8'hD4, 1'b0);
        n_checks++;
        if ({b_m_valid, b_m_data, b_m_keep, b_m_last} !== {1'b1, 32'hD4C3B2A1, 4'hF, 1'b0}) begin
            n_fail++;
            $display("FAIL lsb_word: got v=%b d=%h k=%h l=%b expected 1 d4c3b2a1 f 0",
                     b_m_valid, b_m_data, b_m_keep, b_m_last);
        end
        tick();
        n_checks++;
        if (b_word_cnt !== 4'd1) begin
            n_fail++; $display("FAIL lsb_cnt: got %0d expected 1", b_word_cnt);
        end
    endtask

    task automatic test_flush;
        c_m_ready = 1'b1;
        c_beat(8'h11, 1'b0);
        c_beat(8'h22, 1'b1);
        n_checks++;
        if ({c_m_valid, c_m_data, c_m_keep, c_m_last} !== {1'b1, 32'h11220000, 4'b1100, 1'b1}) begin
            n_fail++;
            $display("FAIL flush_word: got v=%b d=%h k=%b l=%b expected 1 11220000 1100 1",
                     c_m_valid, c_m_data, c_m_keep, c_m_last);
        end
        // single-beat word replaces the previous one in the same cycle it drains
        c_beat(8'h33, 1'b1);
        n_checks++;
        if ({c_m_valid, c_m_data, c_m_keep, c_m_last, c_word_cnt} !==
            {1'b1, 32'h33000000, 4'b1000, 1'b1, 32'd1}) begin
            n_fail++;
            $display("FAIL flush_single: got v=%b d=%h k=%b l=%b cnt=%0d expected 1 33000000 1000 1 1",
                     c_m_valid, c_m_data, c_m_keep, c_m_last, c_word_cnt);
        end
        c_beat(8'h44, 1'b0);
        c_beat(8'h55, 1'b0);
        c_beat(8'h66, 1'b0);
        n_checks++;
        if ({c_m_valid, c_word_cnt} !== {1'b0, 32'd2}) begin
            n_fail++; $display("FAIL flush_drain: got v=%b cnt=%0d expected 0 2", c_m_valid, c_word_cnt);
        end
        c_beat(8'h77, 1'b0);
        n_checks++;
        if ({c_m_valid, c_m_data, c_m_keep, c_m_last} !== {1'b1, 32'h44556677, 4'hF, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_full: got v=%b d=%h k=%h l=%b expected 1 44556677 f 0",
                     c_m_valid, c_m_data, c_m_keep, c_m_last);
        end
        tick();
    endtask

    task automatic test_stall;
        logic [15:0] d [8];
        int sent = 0;
        int got  = 0;
        logic [31:0] w;
        for (int i = 0; i < 8; i++) d[i] = 16'hC000 + 16'(i);
        for (int cyc = 0; cyc < 100 && got < 4; cyc++) begin
            a_s_valid = (sent < 8);
            a_s_data  = (sent < 8) ? d[sent] : 16'h0;
            a_s_last  = 1'b0;
            a_m_ready = (cyc >= 2 && cyc < 7) ? 1'b0 : 1'b1;
            #1;
            if (cyc >= 2 && cyc < 7) begin
                n_checks++;
                if ({a_s_ready, a_m_valid, a_m_data, a_m_keep} !== {1'b0, 1'b1, 32'hC000C001, 2'b11}) begin
                    n_fail++;
                    $display("FAIL stall_hold cyc%0d: got rdy=%b v=%b d=%h k=%b expected 0 1 c000c001 11",
                             cyc, a_s_ready, a_m_valid, a_m_data, a_m_keep);
                end
            end
            if (a_m_valid && a_m_ready) begin
                w = {d[2*got], d[2*got+1]};
                n_checks++;
                if (a_m_data !== w) begin
                    n_fail++; $display("FAIL stall_order word%0d: got %h expected %h", got, a_m_data, w);
                end
                got++;
            end
            if (a_s_valid && a_s_ready) sent++;
            tick();
        end
        a_s_valid = 1'b0;
        n_checks++;
        if (got != 4 || a_word_cnt !== 32'd6) begin
            n_fail++; $display("FAIL stall_cnt: got words=%0d cnt=%0d expected 4 6", got, a_word_cnt);
        end
    endtask

    task automatic test_reset_mid;
        a_m_ready = 1'b1;
        a_beat(16'h5555, 1'b0);
        rst_n     = 1'b0;
        a_s_valid = 1'b1;
        a_s_data  = 16'h9999;
        tick();
        n_checks++;
        if ({a_m_valid, a_m_data, a_m_keep, a_m_last, a_word_cnt, a_s_ready} !==
            {1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_mid: got v=%b d=%h k=%b l=%b cnt=%h rdy=%b, expected all 0 and rdy=1",
                     a_m_valid, a_m_data, a_m_keep, a_m_last, a_word_cnt, a_s_ready);
        end
        rst_n     = 1'b1;
        a_s_valid = 1'b0;
        a_beat(16'hAAAA, 1'b0);
        a_beat(16'hBBBB, 1'b0);
        n_checks++;
        if ({a_m_valid, a_m_data, a_m_keep, a_m_last} !== {1'b1, 32'hAAAABBBB, 2'b11, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_word: got v=%b d=%h k=%b l=%b expected 1 aaaabbbb 11 0",
                     a_m_valid, a_m_data, a_m_keep, a_m_last);
        end
        tick();
    endtask

    task automatic test_wrap;
        logic ready_ok = 1'b1;
        b_m_ready = 1'b1;
        for (int w = 0; w < 17; w++) begin
            for (int k = 0; k < 4; k++) begin
                b_s_valid = 1'b1;
                b_s_data  = 8'($urandom);
                b_s_last  = 1'b0;
                #1;
                if (!b_s_ready) ready_ok = 1'b0;
                tick();
            end
        end
        b_s_valid = 1'b0;
        tick();
        n_checks++;
        if (b_word_cnt !== 4'd1) begin
            n_fail++; $display("FAIL wrap_cnt: got %0d expected 1", b_word_cnt);
        end
        n_checks++;
        if (ready_ok !== 1'b1) begin
            n_fail++; $display("FAIL wrap_throughput: s_ready dropped=%b expected never", !ready_ok);
        end
    endtask

    task automatic test_random;
        localparam int NBEATS  = 10000;
        localparam int CYC_MAX = 60000;
        logic [7:0]  cur_b [$];
        logic [31:0] eq_data [$];
        logic [3:0]  eq_keep [$];
        logic        eq_last [$];
        logic [31:0] wd;
        logic [3:0]  wk;
        int accepted = 0;
        int xfers    = 0;
        int cyc      = 0;
        logic hold   = 1'b0;
        c_s_valid = 1'b0;
        while ((accepted < NBEATS || eq_data.size() != 0) && cyc < CYC_MAX) begin
            if (!hold) begin
                c_s_valid = (accepted < NBEATS) && ($urandom_range(1) == 1);
                c_s_data  = 8'($urandom);
                c_s_last  = (accepted == NBEATS - 1) || ($urandom_range(3) == 0);
            end
            c_m_ready = ($urandom_range(1) == 1);
            #1;
            n_checks++;
            if (c_s_ready !== (!c_m_valid || c_m_ready)) begin
                n_fail++; $display("FAIL rand_ready cyc%0d: got %b expected %b", cyc, c_s_ready,
                                   !c_m_valid || c_m_ready);
            end
            n_checks++;
            if (c_m_valid !== (eq_data.size() != 0)) begin
                n_fail++; $display("FAIL rand_valid cyc%0d: got %b expected %b", cyc, c_m_valid,
                                   eq_data.size() != 0);
            end
            if (c_m_valid && c_m_ready && eq_data.size() != 0) begin
                n_checks++;
                if ({c_m_data, c_m_keep, c_m_last} !== {eq_data[0], eq_keep[0], eq_last[0]}) begin
                    n_fail++;
                    $display("FAIL rand_word%0d: got d=%h k=%b l=%b expected d=%h k=%b l=%b", xfers,
                             c_m_data, c_m_keep, c_m_last, eq_data[0], eq_keep[0], eq_last[0]);
                end
                void'(eq_data.pop_front());
                void'(eq_keep.pop_front());
                void'(eq_last.pop_front());
                xfers++;
            end
            if (c_s_valid && c_s_ready) begin
                cur_b.push_back(c_s_data);
                accepted++;
                if (cur_b.size() == 4 || c_s_last) begin
                    wd = '0;
                    wk = '0;
                    for (int k = 0; k < cur_b.size(); k++) begin
                        wd = wd | (32'(cur_b[k]) << (8 * (3 - k)));
                        wk[3 - k] = 1'b1;
                    end
                    eq_data.push_back(wd);
                    eq_keep.push_back(wk);
                    eq_last.push_back(c_s_last);
                    cur_b.delete();
                end
            end
            hold = c_s_valid && !c_s_ready;
            cyc++;
            tick();
        end
        c_s_valid = 1'b0;
        n_checks++;
        if (cyc >= CYC_MAX) begin
            n_fail++; $display("FAIL rand_timeout: got %0d beats %0d pending expected all drained",
                               accepted, eq_data.size());
        end
        n_checks++;
        if (c_word_cnt !== 32'(xfers)) begin
            n_fail++; $display("FAIL rand_cnt: got %0d expected %0d", c_word_cnt, xfers);
        end
    endtask

    initial begin
        a_s_data = '0; a_s_valid = 1'b0; a_s_last = 1'b0; a_m_ready = 1'b1;
        b_s_data = '0; b_s_valid = 1'b0; b_s_last = 1'b0; b_m_ready = 1'b1;
        c_s_data = '0; c_s_valid = 1'b0; c_s_last = 1'b0; c_m_ready = 1'b1;
        test_reset();
        test_basic();
        test_lsb_first();
        test_flush();
        test_stall();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cmlk_3d_width_upsizer.md
Name: cmlk_3d_width_upsizer

Overview:
Parametrised stream width up-converter. It packs RATIO consecutive DIN_W-bit input beats into one DIN_W*RATIO-bit output word. It sits between the 3D sensor pixel stream and the image packager / DMA write path. Compared with the fixed 16->32 repacker it adds:
- Configurable width, ratio and lane order.
- Full valid/ready backpressure on both sides.
- Early flush on s_last, with a per-lane keep mask.
- An output word counter.

Parameters:
DIN_W, 16, input beat width in bits (>=1)
RATIO, 2, input beats per output word (>=2); DOUT_W = DIN_W*RATIO
MSB_FIRST, 1, 1: first beat of a word goes to the most-significant lane; 0: first beat goes to lane 0 (LSBs)
CNT_W, 32, width of the output word counter

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
s_data  in  DIN_W  input beat
s_valid  in  1  input beat valid
s_last  in  1  last beat of a frame/packet; forces a flush
s_ready  out  1  block can accept a beat
m_data  out  DIN_W*RATIO  packed output word
m_keep  out  RATIO  lane-valid mask; bit i qualifies lane i = m_data[i*DIN_W +: DIN_W]
m_last  out  1  word contains the s_last beat
m_valid  out  1  output word valid
m_ready  in  1  downstream accepts the word
word_cnt  out  CNT_W  number of words transferred (m_valid && m_ready), wraps at 2^CNT_W

Behaviour:
- Beat accepted: acc = s_valid && s_ready. Word transferred: xfer = m_valid && m_ready.
- s_ready = !m_valid || m_ready. Purely combinational from registered m_valid and input m_ready; it never depends on s_valid or s_last.
- Assembly state:
  - acc_data (DOUT_W), acc_keep (RATIO), beat index idx (0..RATIO-1).
  - Lane for beat idx: RATIO-1-idx when MSB_FIRST=1, idx when MSB_FIRST=0.
- On acc, the word completes when idx==RATIO-1 or s_last==1:
  - Not complete: write s_data into its lane, set that lane's acc_keep bit, idx <= idx+1.
  - Complete: on the next edge, m_data <= acc_data with the current beat merged; m_keep <= acc_keep with the current lane's bit set; m_last <= s_last; m_valid <= 1.
  - In the same edge, acc_data <= 0, acc_keep <= 0, idx <= 0.
- Latency: completing beat accepted at edge t -> m_valid high after edge t. One-cycle latency.
- Throughput: one beat per cycle while m_ready stays high; back-to-back words are sustained.
- Lanes not written in a flushed word read 0 and have their m_keep bit cleared. A full word has m_keep all ones.
- Output register update rules:
  - If a completion coincides with xfer, the new word replaces the old one; m_valid stays 1.
  - If xfer occurs without a completion, m_valid <= 0.
  - m_data, m_keep and m_last hold stable while m_valid && !m_ready.
- Stall: while m_valid && !m_ready, s_ready = 0. Upstream holds its beat; no data is lost or reordered.
- s_last on beat 0 produces a single-lane word: keep = one-hot of the first lane, m_last = 1.
- s_valid low: all state holds. Partial accumulation persists indefinitely with no timeout flush.
- word_cnt increments by 1 on every xfer and wraps modulo 2^CNT_W.
- Reset (rst_n=0 at an edge), including mid-word and mid-stall:
  - Clears acc_data, acc_keep, idx, m_data, m_keep, m_last, m_valid and word_cnt to 0.
  - Partial words are discarded.
  - While rst_n is low, s_ready = 1 (m_valid = 0), but accepted beats are ignored.

Decomposition:
- Shared package cmlk_3d_pkg:
  - Function lane_sel(idx, RATIO, MSB_FIRST).
  - Localparam helpers: DOUT_W, IDX_W = $clog2(RATIO).
- One natural sub-module, cmlk_3d_upsizer_outreg: the m_data/m_keep/m_last/m_valid holding register with the xfer/load rules and word_cnt.
- Top level keeps the accumulator and idx logic.

Test Plan:
1. Defaults, m_ready=1, beats 0x1111, 0x2222, 0x3333, 0x4444 (no s_last) -> m_data 0x11112222 then 0x33334444, m_keep=2'b11, m_last=0, each m_valid one cycle after the second beat; word_cnt=2.
2. MSB_FIRST=0, RATIO=4, DIN_W=8, beats 0xA1, 0xB2, 0xC3, 0xD4 -> m_data 0xD4C3B2A1, m_keep=4'hF.
3. RATIO=4, DIN_W=8, MSB_FIRST=1, beats 0x11, 0x22 with s_last on 0x22 -> m_data 0x11220000, m_keep=4'b1100, m_last=1. Next beat 0x33 starts a fresh word in lane 3.
4. Defaults, m_ready=0 for 5 cycles with s_valid continuously high -> first word holds stable, s_ready=0 throughout, no beat dropped. After m_ready=1, the output word sequence matches the input order exactly; word_cnt counts only xfers.
5. Reset after one beat of a word (idx=1) -> all outputs 0. Post-reset beats 0xAAAA, 0xBBBB -> m_data 0xAAAABBBB (stale beat discarded).
6. CNT_W=4, 17 word transfers -> word_cnt reads 1 (wrap). Random s_valid/m_ready at 50% density for 10k beats -> reference-model match and no loss.
